verdict_collector: RTL and testbench

VERDICT_COLLECTOR -- requirements
Module: verdict_collector

---
 rtl/verdict_collector.sv | 132 +++++++++++++
 tb/tb_verdict_collector.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/verdict_collector.sv
// verdict_collector
//   Captures monitor verdicts into a first-word-fall-through record FIFO.
//   Each record holds the cycle timestamp, the two activity flags and the two
//   stream values (inactive values stored as zero).
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous, active-low reset
//   en             enables the timestamp counter and capture
//   output_0/1     signed stream values
//   output_0/1_aktv stream valid flags
//   rec_valid/rec_ready  head-record handshake (pop on valid & ready)
//   rec_ts, rec_aktv, rec_out0, rec_out1  head record fields (0 when empty)
//   level          number of stored records
//   overflow       sticky drop flag
//   drop_cnt       saturating drop counter
//   clr_ovf        synchronous clear of overflow and drop_cnt
module verdict_collector #(
  parameter int DATA_W = 64,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_W-1:0]        output_0,
  input  logic                     output_0_aktv,
  input  logic [DATA_W-1:0]        output_1,
  input  logic                     output_1_aktv,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [TS_W-1:0]          rec_ts,
  output logic [1:0]               rec_aktv,
  output logic [DATA_W-1:0]        rec_out0,
  output logic [DATA_W-1:0]        rec_out1,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Record storage; not reset, validity is tracked by level_q alone.
  logic [TS_W-1:0]   ts_mem   [DEPTH];
  logic [1:0]        aktv_mem [DEPTH];
  logic [DATA_W-1:0] v0_mem   [DEPTH];
  logic [DATA_W-1:0] v1_mem   [DEPTH];

  logic [TS_W-1:0] ts_q,    ts_d;
  logic [AW-1:0]   wptr_q,  wptr_d;
  logic [AW-1:0]   rptr_q,  rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q,   ovf_d;
  logic [15:0]     cnt_q,   cnt_d;

  logic capture, pop, full, wr, drop;

  always_comb begin
    capture = en & (output_0_aktv | output_1_aktv);
    pop     = (level_q != '0) & rec_ready;
    full    = (level_q == LW'(DEPTH));
    // When full, a same-edge pop frees the slot the write pointer points at.
    wr      = capture & (~full | pop);
    drop    = capture & full & ~pop;
  end

  always_comb begin
    ts_d    = en ? ts_q + 1'b1 : ts_q;
    wptr_d  = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    case ({wr, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    // A drop on the clearing edge wins: it counts as the first new drop.
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf)                cnt_d = 16'd1;
      else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ts_q    <= ts_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      ts_mem[wptr_q]   <= ts_q;
      aktv_mem[wptr_q] <= {output_1_aktv, output_0_aktv};
      v0_mem[wptr_q]   <= output_0_aktv ? output_0 : '0;
      v1_mem[wptr_q]   <= output_1_aktv ? output_1 : '0;
    end
  end

  // Head record is read combinationally so it falls through the cycle after
  // the write; fields are forced to zero while the FIFO is empty.
  always_comb begin
    rec_valid = (level_q != '0);
    rec_ts    = rec_valid ? ts_mem[rptr_q]   : '0;
    rec_aktv  = rec_valid ? aktv_mem[rptr_q] : '0;
    rec_out0  = rec_valid ? v0_mem[rptr_q]   : '0;
    rec_out1  = rec_valid ? v1_mem[rptr_q]   : '0;
    level     = level_q;
    overflow  = ovf_q;
    drop_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_verdict_collector.sv
module tb_verdict_collector;

  localparam int DW = 64;
  localparam int TW = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [DW-1:0] o0 = '0, o1 = '0;
  logic a0 = 1'b0, a1 = 1'b0;
  logic rdy = 1'b0, clr = 1'b0;

  logic rec_valid;
  logic [TW-1:0] rec_ts;
  logic [1:0] rec_aktv;
  logic [DW-1:0] rec_out0, rec_out1;
  logic [3:0] level;
  logic overflow;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  verdict_collector #(.DATA_W(DW), .TS_W(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n), .en(en),
    .output_0(o0), .output_0_aktv(a0),
    .output_1(o1), .output_1_aktv(a1),
    .rec_valid(rec_valid), .rec_ready(rdy),
    .rec_ts(rec_ts), .rec_aktv(rec_aktv),
    .rec_out0(rec_out0), .rec_out1(rec_out1),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt),
    .clr_ovf(clr)
  );

  // Reference model: a queue of records plus the scalar status.
  typedef struct {
    logic [TW-1:0] ts;
    logic [1:0]    a;
    logic [DW-1:0] v0;
    logic [DW-1:0] v1;
  } rec_t;

  rec_t        q[$];
  logic [TW-1:0] m_ts = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_cnt = '0;

  task automatic model_reset();
    q.delete();
    m_ts = '0;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  // One rising edge: apply the behavioural rules to the inputs present
  // before the edge, then settle 1 time unit later.
  task automatic tick();
    bit cap, pop, full, drop;
    rec_t r;
    @(posedge clk);
    if (rst_n) begin
      cap  = en && (a0 || a1);
      pop  = (q.size() != 0) && rdy;
      full = (q.size() == DEPTH);
      drop = cap && full && !pop;
      if (pop) void'(q.pop_front());
      if (cap && !drop) begin
        r.ts = m_ts; r.a = {a1, a0};
        r.v0 = a0 ? o0 : '0; r.v1 = a1 ? o1 : '0;
        q.push_back(r);
      end
      if (drop) begin
        m_ovf = 1'b1;
        if (clr) m_cnt = 16'd1;
        else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (clr) begin
        m_ovf = 1'b0;
        m_cnt = '0;
      end
      if (en) m_ts = m_ts + 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    a0 = 0; a1 = 0; o0 = '0; o1 = '0; rdy = 0; clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    en = 0; rst_n = 0;
    #2;
    n_checks++;
    if (rec_valid !== 1'b0 || level !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_valid: rec_valid=%0b level=%0d, expected 0/0", rec_valid, level);
    end
    n_checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0 || rec_ts !== '0 || rec_out0 !== '0) begin
      n_errors++;
      $display("FAIL reset_fields: ovf=%0b cnt=%0d ts=%0d out0=%0h, expected all 0",
               overflow, drop_cnt, rec_ts, rec_out0);
    end
    $display("test_reset: done");
  endtask

  task automatic test_first_capture();
    @(negedge clk);
    rst_n = 1; model_reset();
    en = 1;
    tick(); tick();
    a0 = 1; o0 = 64'd5;
    tick();
    a0 = 0; o0 = '0;
    n_checks++;
    if (rec_valid !== 1'b1 || rec_ts !== 32'd2 || rec_aktv !== 2'b01 ||
        rec_out0 !== 64'd5 || rec_out1 !== 64'd0) begin
      n_errors++;
      $display("FAIL first_capture: valid=%0b ts=%0d aktv=%b out0=%0d out1=%0d, expected 1/2/01/5/0",
               rec_valid, rec_ts, rec_aktv, rec_out0, rec_out1);
    end
    $display("test_first_capture: ts=%0d out0=%0d", rec_ts, rec_out0);
    rdy = 1; tick(); rdy = 0;
  endtask

  task automatic test_signed();
    logic signed [DW-1:0] e0;
    e0 = -64'sd7;
    rdy = 1; a0 = 1; a1 = 1; o0 = e0; o1 = 64'd9;
    tick();
    a0 = 0; a1 = 0;
    n_checks++;
    if (rec_valid !== 1'b1 || rec_aktv !== 2'b11 || $signed(rec_out0) !== e0 ||
        rec_out1 !== 64'd9 || level !== 4'd1) begin
      n_errors++;
      $display("FAIL signed_rec: valid=%0b aktv=%b out0=%0d out1=%0d level=%0d, expected 1/11/-7/9/1",
               rec_valid, rec_aktv, $signed(rec_out0), rec_out1, level);
    end
    tick();
    n_checks++;
    if (level !== 4'd0 || rec_valid !== 1'b0 || rec_out0 !== '0) begin
      n_errors++;
      $display("FAIL signed_drain: level=%0d valid=%0b out0=%0h, expected 0/0/0", level, rec_valid, rec_out0);
    end
    rdy = 0;
    $display("test_signed: done");
  endtask

  task automatic test_overflow();
    logic [TW-1:0] t0;
    t0 = m_ts;
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      a0 = 1; o0 = 64'(i);
      tick();
    end
    a0 = 0;
    n_checks++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 16'd2) begin
      n_errors++;
      $display("FAIL ovf_status: level=%0d ovf=%0b cnt=%0d, expected 8/1/2", level, overflow, drop_cnt);
    end
    rdy = 1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rec_valid !== 1'b1 || rec_ts !== t0 + TW'(i) || rec_out0 !== 64'(i)) begin
        n_errors++;
        $display("FAIL ovf_drain%0d: valid=%0b ts=%0d out0=%0d, expected 1/%0d/%0d",
                 i, rec_valid, rec_ts, rec_out0, t0 + TW'(i), i);
      end
      tick();
    end
    rdy = 0;
    n_checks++;
    if (level !== 4'd0 || rec_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_empty: level=%0d valid=%0b, expected 0/0", level, rec_valid);
    end
    $display("test_overflow: drained 8 records from ts=%0d", t0);
  endtask

  task automatic test_clear();
    clr = 1; tick(); clr = 0;
    n_checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL clr: ovf=%0b cnt=%0d, expected 0/0", overflow, drop_cnt);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a0 = 1; o0 = 64'(100 + i); tick();
    end
    clr = 1; o0 = 64'd999; tick(); clr = 0; a0 = 0;
    n_checks++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd1 || level !== 4'd8) begin
      n_errors++;
      $display("FAIL clr_drop: ovf=%0b cnt=%0d level=%0d, expected 1/1/8", overflow, drop_cnt, level);
    end
    $display("test_clear: cnt=%0d", drop_cnt);
  endtask

  task automatic test_full_simul();
    rdy = 1; a0 = 1; o0 = 64'hABC;
    tick();
    a0 = 0; rdy = 0;
    n_checks++;
    if (level !== 4'd8 || drop_cnt !== 16'd1 || rec_out0 !== 64'd101) begin
      n_errors++;
      $display("FAIL full_simul: level=%0d cnt=%0d head=%0d, expected 8/1/101", level, drop_cnt, rec_out0);
    end
    rdy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (rec_out0 !== q[0].v0 || rec_ts !== q[0].ts) begin
        n_errors++;
        $display("FAIL full_order%0d: out0=%0h ts=%0d, expected %0h/%0d", i, rec_out0, rec_ts, q[0].v0, q[0].ts);
      end
      if (i == DEPTH - 1) begin
        n_checks++;
        if (rec_out0 !== 64'hABC) begin
          n_errors++;
          $display("FAIL full_last: out0=%0h, expected abc", rec_out0);
        end
      end
      tick();
    end
    rdy = 0;
    $display("test_full_simul: done");
  endtask

  task automatic test_enable();
    logic [TW-1:0] frozen;
    a0 = 1; o0 = 64'd3; tick(); a0 = 0;   // one stored record
    frozen = m_ts;
    en = 0; a0 = 1; a1 = 1; o0 = 64'd1; o1 = 64'd2;
    rdy = 1;
    for (int i = 0; i < 5; i++) tick();
    rdy = 0;
    n_checks++;
    if (level !== 4'd0 || rec_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL en_hold: level=%0d valid=%0b, expected 0/0 (pop allowed, no capture)", level, rec_valid);
    end
    en = 1; tick(); en = 1; a0 = 0; a1 = 0;
    n_checks++;
    if (rec_ts !== frozen || rec_aktv !== 2'b11 || level !== 4'd1) begin
      n_errors++;
      $display("FAIL en_frozen: ts=%0d aktv=%b level=%0d, expected %0d/11/1", rec_ts, rec_aktv, level, frozen);
    end
    rdy = 1; tick(); rdy = 0;
    $display("test_enable: frozen ts=%0d", frozen);
  endtask

  task automatic test_random();
    int errs_before;
    logic [TW-1:0] e_ts; logic [1:0] e_a; logic [DW-1:0] e0, e1;
    errs_before = n_errors;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      a0  = $urandom_range(0, 1); a1 = $urandom_range(0, 1);
      o0  = {$urandom, $urandom}; o1 = {$urandom, $urandom};
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 30) == 0);
      tick();
      if (q.size() != 0) begin
        e_ts = q[0].ts; e_a = q[0].a; e0 = q[0].v0; e1 = q[0].v1;
      end else begin
        e_ts = '0; e_a = '0; e0 = '0; e1 = '0;
      end
      n_checks++;
      if (rec_valid !== (q.size() != 0) || level !== 4'(q.size()) ||
          rec_ts !== e_ts || rec_aktv !== e_a || rec_out0 !== e0 || rec_out1 !== e1 ||
          overflow !== m_ovf || drop_cnt !== m_cnt) begin
        n_errors++;
        $display("FAIL random%0d: v=%0b lvl=%0d ts=%0d a=%b o0=%0h o1=%0h ovf=%0b cnt=%0d exp v=%0b lvl=%0d ts=%0d a=%b o0=%0h o1=%0h ovf=%0b cnt=%0d",
                 i, rec_valid, level, rec_ts, rec_aktv, rec_out0, rec_out1, overflow, drop_cnt,
                 q.size() != 0, q.size(), e_ts, e_a, e0, e1, m_ovf, m_cnt);
      end
    end
    idle_inputs(); en = 1;
    $display("test_random: 400 cycles, %0d new errors", n_errors - errs_before);
  endtask

  task automatic test_reset_mid();
    rdy = 0; clr = 1; tick(); clr = 0;
    rdy = 1; for (int i = 0; i < DEPTH; i++) tick(); rdy = 0;
    for (int i = 0; i < 3; i++) begin
      a0 = 1; o0 = 64'(i + 50); tick();
    end
    a0 = 0;
    n_checks++;
    if (rec_valid !== 1'b1 || level !== 4'd3) begin
      n_errors++;
      $display("FAIL mid_pre: valid=%0b level=%0d, expected 1/3", rec_valid, level);
    end
    #2 rst_n = 0; model_reset();
    #1;
    n_checks++;
    if (rec_valid !== 1'b0 || level !== 4'd0 || rec_ts !== '0 || rec_out0 !== '0) begin
      n_errors++;
      $display("FAIL mid_async: valid=%0b level=%0d ts=%0d out0=%0h, expected 0/0/0/0",
               rec_valid, level, rec_ts, rec_out0);
    end
    @(negedge clk); rst_n = 1;
    a0 = 1; o0 = 64'd77; tick(); a0 = 0;
    n_checks++;
    if (rec_ts !== 32'd0 || level !== 4'd1 || rec_out0 !== 64'd77) begin
      n_errors++;
      $display("FAIL mid_after: ts=%0d level=%0d out0=%0d, expected 0/1/77", rec_ts, level, rec_out0);
    end
    $display("test_reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_first_capture();
    test_signed();
    test_overflow();
    test_clear();
    test_full_simul();
    test_enable();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
